// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the button event controller.
package btn_evt_pkg;

    // Debounce channel state encoding, shared by every channel.
    typedef enum logic [1:0] {
        ST_IDLE          = 2'b00,
        ST_PRESS_CHECK   = 2'b01,
        ST_PRESSED       = 2'b10,
        ST_RELEASE_CHECK = 2'b11
    } ch_state_t;

    // Event type carried on evt_press / ptype.
    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    // True while the debounced button counts as held.
    function automatic logic state_is_held(input ch_state_t s);
        return (s == ST_PRESSED) || (s == ST_RELEASE_CHECK);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: advances on the shared sample tick, reports the
// debounced level and a one-cycle event strobe when a press or release is
// confirmed. The FSM state is kept in the named register 'state'.
module btn_debounce_ch
    import btn_evt_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic bs,
    output logic level,
    output logic evt_stb,
    output logic evt_type
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    // cnt + 1 == STABLE_CNT is the same test as cnt == STABLE_CNT - 1
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    ch_state_t       state;
    logic [CW-1:0]   cnt;
    logic            press_done;
    logic            release_done;

    // Debounce FSM and agreeing-sample counter, advanced only on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!bs) begin
                        state <= ST_PRESS_CHECK;
                        cnt   <= CW'(1);
                    end
                end
                ST_PRESS_CHECK: begin
                    if (bs) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (bs) begin
                        state <= ST_RELEASE_CHECK;
                        cnt   <= CW'(1);
                    end
                end
                ST_RELEASE_CHECK: begin
                    if (!bs) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // The strobe is decoded from the transition condition so the pending
    // store latches it on the very edge where the state changes.
    assign press_done   = tick && (state == ST_PRESS_CHECK) && !bs && (cnt == CNT_LAST);
    assign release_done = tick && (state == ST_RELEASE_CHECK) && bs && (cnt == CNT_LAST);

    assign evt_stb  = press_done || release_done;
    assign evt_type = press_done ? EVT_PRESS : EVT_RELEASE;
    assign level    = state_is_held(state);

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounce controller and event scheduler for active-low push-buttons.
// Holds the input synchronisers, sample prescaler, per-channel pending
// store, round-robin arbiter and the registered event output slot.
//
// Event port handshake: an event transfers on a rising clk edge where
// evt_valid and evt_ready are both 1. Once evt_valid is raised it stays
// high, with evt_id/evt_press unchanged, until that transfer happens;
// evt_ready may be driven independently of evt_valid.
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 1000,
    parameter int STABLE_CNT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_BTN-1:0]           btn,
    output logic [N_BTN-1:0]           level,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(N_BTN)-1:0]   evt_id,
    output logic                       evt_press,
    output logic                       overrun
);

    localparam int ID_W = $clog2(N_BTN);
    localparam int PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [ID_W-1:0] ID_LAST   = ID_W'(N_BTN - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] bs;
    logic [PW-1:0]    pcnt;
    logic             tick;
    logic [N_BTN-1:0] evt_stb;
    logic [N_BTN-1:0] evt_type;
    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] ptype;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  scan_idx;
    logic             found;
    logic             load;
    logic             take;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            bs    <= '1;
        end else begin
            sync1 <= btn;
            bs    <= sync1;
        end
    end

    // Free-running prescaler; tick marks its last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (pcnt == PCNT_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign tick = (pcnt == PCNT_LAST);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CNT(STABLE_CNT)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .bs       (bs[i]),
            .level    (level[i]),
            .evt_stb  (evt_stb[i]),
            .evt_type (evt_type[i])
        );
    end

    // Round-robin scan: first pending channel at or after rr_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = '0;
        for (int off = 0; off < N_BTN; off++) begin
            scan_idx = ID_W'((int'(rr_ptr) + off) % N_BTN);
            if (!found && pend[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    // The slot reloads whenever it is empty or its event is being taken.
    assign load = !evt_valid || evt_ready;
    assign take = load && found;

    // Pending store: a new event always wins over the clear from a load,
    // so on a same-cycle set/load the old event leaves and the new one stays.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= '0;
            ptype <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (evt_stb[i]) begin
                    pend[i]  <= 1'b1;
                    ptype[i] <= evt_type[i];
                end else if (take && (sel == ID_W'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky overrun: an unread pending event was overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (evt_stb[i] && pend[i] && !(take && (sel == ID_W'(i)))) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // Output slot and round-robin pointer; contents only change on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_press <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            evt_valid <= found;
            if (found) begin
                evt_id    <= sel;
                evt_press <= ptype[sel];
                rr_ptr    <= (sel == ID_LAST) ? '0 : sel + ID_W'(1);
            end
        end
    end

endmodule
